// File: rtl/accel_request_ctrl_if.sv
// accel_request_ctrl_if: request/response valid-ready bus between the MEM-stage requester and the accelerator
interface accel_request_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, op, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, op, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/accel_request_ctrl.sv
// accel_request_ctrl: MEM-stage accelerator requester that stalls the pipeline until the response returns; ACCEL_TIMEOUT_EN adds a forced completion after TIMEOUT response-wait cycles
module accel_request_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_mem,
    input  logic [OP_W-1:0]   req_op_mem,
    input  logic [ADDR_W-1:0] req_addr_mem,
    input  logic [DATA_W-1:0] req_wdata_mem,
    output logic              stall_flag,
    output logic              request_finish,
    output logic [DATA_W-1:0] result,
    output logic              result_err,
    accel_request_ctrl_if.master acc
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state;
    logic   timeout_hit;

`ifdef ACCEL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    // the counter holds the number of already-elapsed empty WAIT cycles, so the last allowed one hits at TIMEOUT-1
    assign timeout_hit = wait_cnt == CNT_W'(TIMEOUT - 1);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // stall starts combinationally the cycle the op reaches MEM and is held through DONE
    assign stall_flag = rst && (state != IDLE || req_valid_mem);

    // request/response sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            acc.req_valid  <= 1'b0;
            acc.rsp_ready  <= 1'b0;
            acc.op         <= '0;
            acc.addr       <= '0;
            acc.wdata      <= '0;
            request_finish <= 1'b0;
            result         <= '0;
            result_err     <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid_mem) begin
                    state         <= REQ;
                    acc.req_valid <= 1'b1;
                    acc.op        <= req_op_mem;
                    acc.addr      <= req_addr_mem;
                    acc.wdata     <= req_wdata_mem;
                end
                REQ: if (acc.req_ready) begin
                    state         <= WAIT;
                    acc.req_valid <= 1'b0;
                    acc.rsp_ready <= 1'b1;
`ifdef ACCEL_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                end
                WAIT: if (acc.rsp_valid || timeout_hit) begin
                    state          <= DONE;
                    acc.rsp_ready  <= 1'b0;
                    request_finish <= 1'b1;
                    result         <= acc.rsp_valid ? acc.rsp_data : '0;
                    result_err     <= acc.rsp_valid ? acc.rsp_err : 1'b1;
                end
`ifdef ACCEL_TIMEOUT_EN
                else wait_cnt <= wait_cnt + 1'b1;
`endif
                DONE: begin
                    state          <= IDLE;
                    request_finish <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_accel_request_ctrl.sv
// tb_accel_request_ctrl: vector table, hand-written corner sequences and a randomized run against a transaction-level model
module tb_accel_request_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rv = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall_flag, request_finish, result_err;
    logic [31:0] result;
    int          tests = 0;
    int          fails = 0;

    accel_request_ctrl_if #(.DATA_W(32), .ADDR_W(32), .OP_W(4)) bus();

    accel_request_ctrl #(.DATA_W(32), .ADDR_W(32), .OP_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid_mem(rv), .req_op_mem(op), .req_addr_mem(addr),
        .req_wdata_mem(wdata), .stall_flag(stall_flag), .request_finish(request_finish),
        .result(result), .result_err(result_err), .acc(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv, rdy, rsv, err;
        logic [31:0] data, addr, e_addr, e_res;
        logic        e_stall, e_reqv, e_rspr, e_fin, e_err;
    } vec_t;

    vec_t tbl[19];

    // transaction-level reference: an op is in flight, has been accepted, has been answered
    bit          m_busy, m_acc, m_done;
    int          m_wait;
    logic [3:0]  m_op;
    logic [31:0] m_addr, m_wdata, m_res;
    logic        m_err;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rv = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err = 1'b0;
        bus.rsp_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic model_step();
        if (m_done) begin
            m_busy = 0; m_acc = 0; m_done = 0;
        end else if (m_busy && m_acc) begin
            if (bus.rsp_valid) begin
                m_res = bus.rsp_data; m_err = bus.rsp_err; m_done = 1;
            end else begin
                m_wait++;
`ifdef ACCEL_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_res = '0; m_err = 1'b1; m_done = 1;
                end
`endif
            end
        end else if (m_busy) begin
            if (bus.req_ready) begin
                m_acc = 1; m_wait = 0;
            end
        end else if (rv) begin
            m_busy = 1; m_op = op; m_addr = addr; m_wdata = wdata;
        end
    endtask

    initial begin
        tbl[0]  = '{1, 1, 1, 0, 32'hCAFE_0001, 32'h100, 32'h0,   32'h0,         1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 32'hCAFE_0001, 32'h100, 32'h100, 32'h0,         1, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 32'hCAFE_0001, 32'h100, 32'h100, 32'h0,         1, 0, 1, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 32'hCAFE_0001, 32'h100, 32'h100, 32'hCAFE_0001, 1, 0, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 0, 32'h0,         32'h200, 32'h100, 32'hCAFE_0001, 1, 0, 0, 0, 0};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{1, 0, 1, 0, 32'hDEAD, 32'h999, 32'h200, 32'hCAFE_0001, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 32'hDEAD,      32'h999, 32'h200, 32'hCAFE_0001, 1, 1, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 32'h0,         32'h999, 32'h200, 32'hCAFE_0001, 1, 0, 1, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 32'h1234,      32'h999, 32'h200, 32'hCAFE_0001, 1, 0, 1, 0, 0};
        tbl[13] = '{1, 1, 1, 0, 32'h0,         32'h999, 32'h200, 32'h1234,      1, 0, 0, 1, 1};
        tbl[14] = '{1, 0, 0, 0, 32'h0,         32'h300, 32'h200, 32'h1234,      1, 0, 0, 0, 1};
        tbl[15] = '{1, 1, 0, 0, 32'h0,         32'h300, 32'h300, 32'h1234,      1, 1, 0, 0, 1};
        tbl[16] = '{1, 0, 1, 0, 32'h5555,      32'h300, 32'h300, 32'h1234,      1, 0, 1, 0, 1};
        tbl[17] = '{0, 0, 0, 0, 32'h0,         32'h300, 32'h300, 32'h5555,      1, 0, 0, 1, 0};
        tbl[18] = '{0, 0, 0, 0, 32'h0,         32'h0,   32'h300, 32'h5555,      0, 0, 0, 0, 0};

        do_reset();
        @(negedge clk);
        chk("reset_stall", stall_flag, 0);
        chk("reset_finish", request_finish, 0);
        chk("reset_req_valid", bus.req_valid, 0);
        chk("reset_result", result, 0);
        next_cycle();

        op = 4'h3;
        wdata = 32'h77;
        for (int i = 0; i < 19; i++) begin
            rv = tbl[i].rv;
            addr = tbl[i].addr;
            bus.req_ready = tbl[i].rdy;
            bus.rsp_valid = tbl[i].rsv;
            bus.rsp_err = tbl[i].err;
            bus.rsp_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), stall_flag, tbl[i].e_stall);
            chk($sformatf("vec%0d_req_valid", i), bus.req_valid, tbl[i].e_reqv);
            chk($sformatf("vec%0d_rsp_ready", i), bus.rsp_ready, tbl[i].e_rspr);
            chk($sformatf("vec%0d_finish", i), request_finish, tbl[i].e_fin);
            chk($sformatf("vec%0d_acc_addr", i), bus.addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_result", i), result, tbl[i].e_res);
            chk($sformatf("vec%0d_result_err", i), result_err, tbl[i].e_err);
            next_cycle();
        end

        // asynchronous reset while waiting for the response
        rv = 1'b1; addr = 32'h400; bus.req_ready = 1'b1; bus.rsp_valid = 1'b0;
        next_cycle();
        next_cycle();
        chk("midwait_rsp_ready", bus.rsp_ready, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_stall", stall_flag, 0);
        chk("async_rsp_ready", bus.rsp_ready, 0);
        chk("async_req_valid", bus.req_valid, 0);
        chk("async_finish", request_finish, 0);
        chk("async_addr", bus.addr, 0);
        chk("async_result", result, 0);
        rv = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_data = 32'hBAD;
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_finish", request_finish, 0);
            chk("post_reset_stall", stall_flag, 0);
            next_cycle();
        end
        bus.rsp_valid = 1'b0;

`ifdef ACCEL_TIMEOUT_EN
        for (int k = 0; k < 2; k++) begin
            rv = 1'b1; bus.req_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_data = 32'hABCD; bus.rsp_err = 1'b0;
            next_cycle();
            next_cycle();
            for (int w = 1; w <= TO; w++) begin
                bus.rsp_valid = (k == 1 && w == TO);
                @(negedge clk);
                chk("to_wait_rsp_ready", bus.rsp_ready, 1);
                chk("to_wait_finish", request_finish, 0);
                next_cycle();
            end
            bus.rsp_valid = 1'b0; rv = 1'b0;
            @(negedge clk);
            chk("to_done_finish", request_finish, 1);
            chk("to_done_result", result, k == 1 ? 32'hABCD : 32'h0);
            chk("to_done_err", result_err, k == 1 ? 1'b0 : 1'b1);
            next_cycle();
        end
`endif

        do_reset();
        m_busy = 0; m_acc = 0; m_done = 0; m_wait = 0;
        m_op = '0; m_addr = '0; m_wdata = '0; m_res = '0; m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rv = $urandom_range(0, 2) != 0;
            op = 4'($urandom);
            addr = $urandom;
            wdata = $urandom;
            bus.req_ready = $urandom_range(0, 1) == 1;
            bus.rsp_valid = $urandom_range(0, 3) == 0;
            bus.rsp_err = $urandom_range(0, 1) == 1;
            bus.rsp_data = $urandom;
            @(negedge clk);
            chk("rnd_stall", stall_flag, m_busy || rv);
            chk("rnd_req_valid", bus.req_valid, m_busy && !m_acc);
            chk("rnd_rsp_ready", bus.rsp_ready, m_acc && !m_done);
            chk("rnd_finish", request_finish, m_done);
            chk("rnd_result", {result_err, result}, {m_err, m_res});
            if (m_busy) chk("rnd_fields", {bus.op, bus.addr, bus.wdata}, {m_op, m_addr, m_wdata});
            model_step();
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
